// File: rtl/xeng_acc_ctrl.sv
// Accumulation-window sequencer for the X-engine: aligns to sync, counts windows of
// 2^SERIAL_ACC_LEN_BITS samples and emits per-lane first/last strobes staggered like the data.
module xeng_acc_ctrl #(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int P_FACTOR_BITS       = 2,
  parameter int LANE_DELAY          = 1,
  parameter int ACC_CNT_BITS        = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ce,
  input  logic                            en,
  input  logic                            sync,
  output logic [(2**P_FACTOR_BITS)-1:0]   acc_first,
  output logic [(2**P_FACTOR_BITS)-1:0]   acc_last,
  output logic                            acc_valid,
  output logic [ACC_CNT_BITS-1:0]         acc_cnt,
  output logic                            sync_err,
  output logic                            busy
);

  localparam int P       = 2**P_FACTOR_BITS;
  localparam int MAX_DLY = (P - 1) * LANE_DELAY;
  localparam logic [SERIAL_ACC_LEN_BITS-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, ACCUM} state_t;

  state_t                         state, state_n;
  logic [SERIAL_ACC_LEN_BITS-1:0] cnt, cnt_n;
  logic                           stop_req, stop_n;
  logic                           err_set, clear;
  logic                           first_n, last_n;

  // Index 0 is the lane-0 strobe register; lane k taps index k*LANE_DELAY.
  logic first_dly [0:MAX_DLY];
  logic last_dly  [0:MAX_DLY];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stop_n  = stop_req;
    err_set = 1'b0;
    clear   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n  = '0;
        stop_n = 1'b0;
        if (en) begin
          state_n = WAIT_SYNC;
          clear   = 1'b1;
        end
      end
      WAIT_SYNC: begin
        cnt_n = '0;
        if (!en)
          state_n = IDLE;
        else if (sync)
          state_n = ACCUM;
      end
      ACCUM: begin
        // A stop request is latched so the window always completes even if en returns.
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (!en || stop_req) begin
            state_n = IDLE;
            stop_n  = 1'b0;
          end
        end else begin
          stop_n = stop_req | ~en;
          if (sync) begin
            cnt_n   = '0;
            err_set = 1'b1;
          end else begin
            cnt_n = cnt + SERIAL_ACC_LEN_BITS'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    first_n = (state_n == ACCUM) && (cnt_n == '0);
    last_n  = (state_n == ACCUM) && (cnt_n == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      stop_req  <= 1'b0;
      acc_valid <= 1'b0;
      busy      <= 1'b0;
      acc_cnt   <= '0;
      sync_err  <= 1'b0;
      for (int i = 0; i <= MAX_DLY; i++) begin
        first_dly[i] <= 1'b0;
        last_dly[i]  <= 1'b0;
      end
    end else if (ce) begin
      state        <= state_n;
      cnt          <= cnt_n;
      stop_req     <= stop_n;
      acc_valid    <= (state_n == ACCUM);
      busy         <= (state_n != IDLE);
      first_dly[0] <= first_n;
      last_dly[0]  <= last_n;
      for (int i = 1; i <= MAX_DLY; i++) begin
        first_dly[i] <= first_dly[i-1];
        last_dly[i]  <= last_dly[i-1];
      end
      if (clear) begin
        acc_cnt  <= '0;
        sync_err <= 1'b0;
      end else begin
        if (last_dly[0])
          acc_cnt <= acc_cnt + ACC_CNT_BITS'(1);
        if (err_set)
          sync_err <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < P; k++) begin : g_lane
    assign acc_first[k] = first_dly[k*LANE_DELAY];
    assign acc_last[k]  = last_dly[k*LANE_DELAY];
  end

endmodule

// File: tb/tb_xeng_acc_ctrl.sv
// Directed bench for xeng_acc_ctrl with L=4, P=4, LANE_DELAY=1; lane strobes are matched
// against a scoreboard of expected (ce-cycle, lane, kind) events.
module tb_xeng_acc_ctrl;

  localparam int SBITS = 2;
  localparam int PBITS = 2;
  localparam int LD    = 1;
  localparam int CW    = 32;
  localparam int L     = 2**SBITS;
  localparam int P     = 2**PBITS;

  logic          clk = 1'b0;
  logic          rst_n, ce, en, sync;
  logic [P-1:0]  acc_first, acc_last;
  logic          acc_valid, sync_err, busy;
  logic [CW-1:0] acc_cnt;

  typedef struct {
    int cyc;
    int lane;
    bit last;
  } ev_t;

  ev_t     sb_q[$];
  int      checks   = 0;
  int      failures = 0;
  int      ccyc     = 0;
  logic    fresh    = 1'b0;
  bit      mon_en   = 1'b0;
  bit      rand_ce  = 1'b0;
  int      t;
  int      s;
  int      a;
  bit      found;
  logic    sbit;
  logic [63:0] snap = '0;

  xeng_acc_ctrl #(
    .SERIAL_ACC_LEN_BITS(SBITS),
    .P_FACTOR_BITS(PBITS),
    .LANE_DELAY(LD),
    .ACC_CNT_BITS(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ce(ce),
    .en(en),
    .sync(sync),
    .acc_first(acc_first),
    .acc_last(acc_last),
    .acc_valid(acc_valid),
    .acc_cnt(acc_cnt),
    .sync_err(sync_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ccyc counts ce-high edges only, so expectations are independent of ce gaps.
  always @(posedge clk) begin
    fresh <= ce;
    if (ce) ccyc <= ccyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sync_v);
    int gap;
    gap  = 0;
    sync = sync_v;
    if (rand_ce) begin
      while ($urandom_range(1, 0) == 1 && gap < 8) begin
        ce = 1'b0;
        @(posedge clk);
        #1;
        gap++;
      end
    end
    ce = 1'b1;
    @(posedge clk);
    #1;
    sync = 1'b0;
  endtask

  task automatic pushEvent(input int cyc, input int lane, input bit last);
    ev_t e;
    e.cyc  = cyc;
    e.lane = lane;
    e.last = last;
    sb_q.push_back(e);
  endtask

  task automatic pushWindow(input int start, input bit with_last);
    for (int k = 0; k < P; k++) begin
      pushEvent(start + k*LD, k, 1'b0);
      if (with_last) pushEvent(start + L - 1 + k*LD, k, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (fresh) begin
        for (int k = 0; k < P; k++) begin
          for (int kind = 0; kind < 2; kind++) begin
            sbit = (kind == 1) ? acc_last[k] : acc_first[k];
            if (sbit) begin
              found = 1'b0;
              for (int j = 0; j < sb_q.size(); j++) begin
                if (!found && sb_q[j].cyc == ccyc && sb_q[j].lane == k && sb_q[j].last == (kind == 1)) begin
                  sb_q.delete(j);
                  found = 1'b1;
                end
              end
              checkOutput($sformatf("strobe_%s_lane%0d_cyc%0d", (kind == 1) ? "last" : "first", k, ccyc),
                          64'(found), 64'(1));
            end
          end
        end
      end else begin
        checkOutput("hold_while_ce_low", 64'({acc_first, acc_last, acc_valid, acc_cnt, sync_err, busy}), snap);
      end
    end
    snap = 64'({acc_first, acc_last, acc_valid, acc_cnt, sync_err, busy});
  end

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    ce    = 1'b0;
    en    = 1'b0;
    sync  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_acc_first", 64'(acc_first), 64'(0));
    checkOutput("rst_acc_last",  64'(acc_last),  64'(0));
    checkOutput("rst_acc_valid", 64'(acc_valid), 64'(0));
    checkOutput("rst_acc_cnt",   64'(acc_cnt),   64'(0));
    checkOutput("rst_sync_err",  64'(sync_err),  64'(0));
    checkOutput("rst_busy",      64'(busy),      64'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("idle_ignores_sync", 64'(busy), 64'(0));

    $display("[TB] first window and 20 aligned windows");
    en = 1'b1;
    applyStimulus(1'b0);
    checkOutput("busy_after_en", 64'(busy), 64'(1));
    checkOutput("wait_not_valid", 64'(acc_valid), 64'(0));
    repeat (3) applyStimulus(1'b0);
    t = ccyc;
    for (int w = 0; w < 20; w++) pushWindow(t + 1 + w*L, 1'b1);
    pushWindow(t + 1 + 20*L, 1'b0);
    applyStimulus(1'b1);
    checkOutput("valid_after_sync", 64'(acc_valid), 64'(1));
    for (int i = 1; i <= 20*L; i++) begin
      if ((i - 1) % L == 0)
        checkOutput($sformatf("acc_cnt_win%0d", (i - 1) / L), 64'(acc_cnt), 64'((i - 1) / L));
      applyStimulus(((i - 1) % L) == L - 1);
    end
    checkOutput("acc_cnt_20", 64'(acc_cnt), 64'(20));
    checkOutput("aligned_no_err", 64'(sync_err), 64'(0));

    $display("[TB] misaligned sync at cnt=1");
    applyStimulus(1'b0);
    a = ccyc;
    pushWindow(a + 1, 1'b1);
    pushWindow(a + 1 + L, 1'b1);
    applyStimulus(1'b1);
    checkOutput("sync_err_set", 64'(sync_err), 64'(1));
    checkOutput("abort_cnt_hold", 64'(acc_cnt), 64'(20));
    repeat (L) applyStimulus(1'b0);
    checkOutput("acc_cnt_after_abort", 64'(acc_cnt), 64'(21));
    checkOutput("sync_err_sticky", 64'(sync_err), 64'(1));

    $display("[TB] en dropped at cnt=1");
    s = ccyc;
    applyStimulus(1'b0);
    en = 1'b0;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("stop_still_busy", 64'(busy), 64'(1));
    checkOutput("stop_cnt_before", 64'(acc_cnt), 64'(21));
    applyStimulus(1'b1);
    checkOutput("stop_idle_busy", 64'(busy), 64'(0));
    checkOutput("stop_idle_valid", 64'(acc_valid), 64'(0));
    checkOutput("stop_cnt_after", 64'(acc_cnt), 64'(22));
    repeat (4) applyStimulus(1'b0);
    checkOutput("drain_sb_empty", 64'(sb_q.size()), 64'(0));
    checkOutput("drain_last_cycle", 64'(ccyc), 64'(s + 8));

    $display("[TB] random ce gating");
    rand_ce = 1'b1;
    en = 1'b1;
    applyStimulus(1'b0);
    checkOutput("rearm_busy", 64'(busy), 64'(1));
    checkOutput("rearm_cnt_clear", 64'(acc_cnt), 64'(0));
    checkOutput("rearm_err_clear", 64'(sync_err), 64'(0));
    applyStimulus(1'b0);
    t = ccyc;
    for (int w = 0; w < 3; w++) pushWindow(t + 1 + w*L, 1'b1);
    applyStimulus(1'b1);
    for (int i = 1; i <= 3*L; i++) begin
      if ((i - 1) % L == 0)
        checkOutput($sformatf("ce_acc_cnt_win%0d", (i - 1) / L), 64'(acc_cnt), 64'((i - 1) / L));
      if (i == 3*L) en = 1'b0;
      applyStimulus(((i - 1) % L) == L - 1);
    end
    checkOutput("ce_acc_cnt_3", 64'(acc_cnt), 64'(3));
    checkOutput("ce_idle", 64'(busy), 64'(0));
    repeat (4) applyStimulus(1'b0);
    checkOutput("ce_sb_empty", 64'(sb_q.size()), 64'(0));
    rand_ce = 1'b0;

    $display("[TB] reset with strobes in flight");
    en = 1'b1;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    t = ccyc;
    for (int k = 0; k < P; k++) pushEvent(t + 1 + k*LD, k, 1'b0);
    for (int k = 0; k < 3; k++) pushEvent(t + L + k*LD, k, 1'b1);
    for (int k = 0; k < 2; k++) pushEvent(t + 1 + L + k*LD, k, 1'b0);
    applyStimulus(1'b1);
    repeat (L + 2) applyStimulus(1'b0);
    checkOutput("pre_reset_cnt", 64'(acc_cnt), 64'(1));
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("mid_rst_first", 64'(acc_first), 64'(0));
    checkOutput("mid_rst_last",  64'(acc_last),  64'(0));
    checkOutput("mid_rst_valid", 64'(acc_valid), 64'(0));
    checkOutput("mid_rst_cnt",   64'(acc_cnt),   64'(0));
    checkOutput("mid_rst_busy",  64'(busy),      64'(0));
    checkOutput("mid_rst_sb_empty", 64'(sb_q.size()), 64'(0));
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (6) applyStimulus(1'b0);
    checkOutput("post_rst_valid", 64'(acc_valid), 64'(0));
    checkOutput("post_rst_busy",  64'(busy),      64'(1));
    t = ccyc;
    pushWindow(t + 1, 1'b1);
    applyStimulus(1'b1);
    en = 1'b0;
    repeat (L + 4) applyStimulus(1'b0);
    checkOutput("post_rst_cnt", 64'(acc_cnt), 64'(1));
    checkOutput("post_rst_idle", 64'(busy), 64'(0));
    checkOutput("final_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xeng_acc_ctrl.md
# xeng_acc_ctrl

Sequencer for the X-engine accumulation chain downstream of the preprocessing stage (uint conversion and lane stagger). It aligns to the upstream sync pulse and counts serial accumulation windows of 2^SERIAL_ACC_LEN_BITS samples. It drives per-lane first/last strobes, staggered to match the data stagger, so every parallel DSP chain starts and dumps on its own sample. It also tracks window count and reports misaligned syncs.

## Interface
- SERIAL_ACC_LEN_BITS, 7: window length L = 2^SERIAL_ACC_LEN_BITS samples (valid 1..16).
- P_FACTOR_BITS, 2: number of parallel lanes P = 2^P_FACTOR_BITS.
- LANE_DELAY, 1: cycles of extra delay per lane index (lane k lags lane 0 by k*LANE_DELAY).
- ACC_CNT_BITS, 32: width of completed-window counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ce  in  1  clock enable; when low, every register (FSM, counters, delay lines, outputs) holds.
- en  in  1  arm/run request.
- sync  in  1  one-cycle pulse; the sample in the following cycle is sample 0 of a window.
- acc_first  out  P  bit k: lane k's current sample is window sample 0.
- acc_last  out  P  bit k: lane k's current sample is window sample L-1.
- acc_valid  out  1  lane 0 is inside a window (state ACCUM).
- acc_cnt  out  ACC_CNT_BITS  completed windows since arming; wraps modulo 2^ACC_CNT_BITS.
- sync_err  out  1  sticky: sync arrived mid-window.
- busy  out  1  state != IDLE.

## Operation
- FSM states:
  - IDLE: counters 0. en=1 -> WAIT_SYNC.
  - WAIT_SYNC: sync=1 -> ACCUM with sample counter cnt=0 next cycle. en=0 -> IDLE.
  - ACCUM: cnt increments 0..L-1 per ce cycle and wraps to 0.
- Leaving IDLE clears acc_cnt and sync_err.
- Lane-0 strobes are a registered decode of next state: first when next cnt=0, last when next cnt=L-1. Both are only active in ACCUM.
- acc_cnt increments in the cycle after lane-0 acc_last.
- Sync in ACCUM:
  - Aligned, cnt=L-1: no effect; the window wraps normally.
  - Any other cnt: set sync_err. Abort the window with no acc_last and no acc_cnt increment. Next cycle is cnt=0 with acc_first.
- en=0 in ACCUM: the current window completes, including acc_last and acc_cnt increment, then IDLE. A sync on that last cycle is ignored.
- en=0 and aligned sync on the same last cycle: go to IDLE.
- L=2: first and last are distinct cycles.
- Lane k > 0: delay line of k*LANE_DELAY ce-cycles on lane-0 first/last. Delay lines continue to drain after returning to IDLE.
- rst_n low mid-operation:
  - All outputs and delay lines go to 0 immediately; state goes to IDLE.
  - Pending lane strobes are discarded.

## Timing
- Reset values: acc_first=0, acc_last=0, acc_valid=0, acc_cnt=0, sync_err=0, busy=0.
- Sync at cycle t (ce high throughout):
  - acc_first[0] and acc_valid high at t+1.
  - acc_last[0] high at t+L.
  - acc_first[k] high at t+1+k*LANE_DELAY.
- acc_cnt updates at t+L+1.
- en rising at t: busy=1 at t+1.
- sync_err rises one cycle after the offending sync.
- ce low for n cycles stretches all timing by n cycles.
- No output toggles while ce is low.

## Test plan
- L=4, P=4, LANE_DELAY=1; en=1, sync at t=10 -> first[0] at 11, last[0] at 14, first[3] at 14, last[3] at 17, acc_cnt=1 at 15, 2 at 19.
- Aligned syncs every 4 cycles for 20 windows -> sync_err stays 0, acc_cnt=20, strobe period exactly 4.
- Sync at cnt=1 -> sync_err=1 next cycle, no last[0] for the aborted window, first[0] next cycle, acc_cnt unchanged.
- en dropped at cnt=1 -> last[0] still at cnt=3, acc_cnt+1, then IDLE; lane 3 strobes still appear 3 cycles later.
- ce toggling 50% random -> strobe sequence identical to the ce=1 run when only ce-high cycles are counted.
- rst_n pulsed low at cnt=2 with lane strobes in flight -> all outputs 0 immediately, no strobes after release until en and a new sync.
